// File: rtl/vec_operand_loader_pkg.sv
// vec_pkg: constants and types shared by the operand loader, its slots and its interface.
//   NIB_W_DEFAULT : default nibble/operand width
//   state_e       : loader states (COLLECT, HOLD)
//   IDX_A..IDX_D  : operand index positions in arrival order
//   nib_parity    : even-parity helper for the optional parity check
package vec_pkg;

  localparam int NIB_W_DEFAULT = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic nib_parity(input logic [NIB_W_DEFAULT-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vec_operand_loader_if.sv
// vec_operand_loader_if: nibble stream in, assembled operand set out.
//   nib_in/nib_valid/nib_ready : serial nibble handshake (producer -> loader)
//   nib_par                    : even parity of nib_in (VEC_OPERAND_LOADER_PARITY_EN only)
//   op_a..op_d/ops_valid/ops_ready : held operand set handshake (loader -> consumer)
// Modports: master = producer/consumer side, slave = loader side.
interface vec_operand_loader_if
  import vec_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEFAULT
);

  logic [NIB_W-1:0] nib_in;
  logic             nib_valid;
  logic             nib_ready;
`ifdef VEC_OPERAND_LOADER_PARITY_EN
  logic             nib_par;
`endif
  logic [NIB_W-1:0] op_a;
  logic [NIB_W-1:0] op_b;
  logic [NIB_W-1:0] op_c;
  logic [NIB_W-1:0] op_d;
  logic             ops_valid;
  logic             ops_ready;

  modport master (
    output nib_in,
    output nib_valid,
    output ops_ready,
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    output nib_par,
`endif
    input  nib_ready,
    input  op_a,
    input  op_b,
    input  op_c,
    input  op_d,
    input  ops_valid
  );

  modport slave (
    input  nib_in,
    input  nib_valid,
    input  ops_ready,
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    input  nib_par,
`endif
    output nib_ready,
    output op_a,
    output op_b,
    output op_c,
    output op_d,
    output ops_valid
  );

endinterface

// File: rtl/vec_operand_loader_slot.sv
// vec_operand_slot: one W-bit operand register with load enable.
//   clk, rst_n : clock, asynchronous active-low reset (clears to zero)
//   load, d    : when load is high, d is captured on the rising edge
//   q          : registered operand value
module vec_operand_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Operand storage: captures d on load, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/vec_operand_loader.sv
// vec_operand_loader: assembles four serial nibbles into operands a..d and holds
// the complete set with ops_valid until the consumer accepts it.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort of a partial or held set (operands retained)
//   bus        : vec_operand_loader_if.slave (nibble stream in, operand set out)
//   set_cnt    : number of sets accepted by the consumer (wraps silently)
//   par_err    : sticky parity error (only with VEC_OPERAND_LOADER_PARITY_EN)
// Optional feature macro: VEC_OPERAND_LOADER_PARITY_EN.
module vec_operand_loader
  import vec_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  vec_operand_loader_if.slave bus,
  output logic [CNT_W-1:0] set_cnt
`ifdef VEC_OPERAND_LOADER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam logic [0:0] ST_COLLECT = 1'(COLLECT);
  localparam logic [0:0] ST_HOLD    = 1'(HOLD);

  logic [0:0]       state_r;
  logic [1:0]       idx_r;
  logic             ops_valid_r;
  logic [CNT_W-1:0] set_cnt_r;
  logic             par_err_r;
  logic             nib_ready_s;
  logic             xfer_s;
  logic             par_bad_s;
  logic [3:0]       load_s;
  logic [NIB_W-1:0] slot_q_s [4];

  // Handshake decode: ready depends only on state and flush, never on nib_valid.
  always_comb begin
    nib_ready_s = 1'b0;
    if ((state_r == ST_COLLECT) && !flush) begin
      nib_ready_s = 1'b1;
    end else begin
      nib_ready_s = 1'b0;
    end
    xfer_s = bus.nib_valid && nib_ready_s;
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    par_bad_s = xfer_s && (bus.nib_par != nib_parity(bus.nib_in));
`else
    par_bad_s = 1'b0;
`endif
  end

  // Slot select: a nibble with bad parity is never written into an operand.
  always_comb begin
    load_s = 4'b0000;
    if (xfer_s && !par_bad_s) begin
      case (idx_r)
        IDX_A:   load_s = 4'b0001;
        IDX_B:   load_s = 4'b0010;
        IDX_C:   load_s = 4'b0100;
        IDX_D:   load_s = 4'b1000;
        default: load_s = 4'b0000;
      endcase
    end else begin
      load_s = 4'b0000;
    end
  end

  // Loader FSM, operand index, completed-set counter and sticky parity flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_COLLECT;
      idx_r       <= IDX_A;
      ops_valid_r <= 1'b0;
      set_cnt_r   <= {CNT_W{1'b0}};
      par_err_r   <= 1'b0;
    end else if (flush) begin
      // Flush beats both a new nibble and a consumer accept; operands stay as they are.
      state_r     <= ST_COLLECT;
      idx_r       <= IDX_A;
      ops_valid_r <= 1'b0;
      par_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (par_bad_s) begin
            idx_r     <= IDX_A;
            par_err_r <= 1'b1;
          end else if (xfer_s && (idx_r == IDX_D)) begin
            state_r     <= ST_HOLD;
            idx_r       <= IDX_A;
            ops_valid_r <= 1'b1;
          end else if (xfer_s) begin
            idx_r <= idx_r + 2'd1;
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_HOLD: begin
          if (bus.ops_ready) begin
            state_r     <= ST_COLLECT;
            idx_r       <= IDX_A;
            ops_valid_r <= 1'b0;
            set_cnt_r   <= set_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            ops_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_COLLECT;
          idx_r       <= IDX_A;
          ops_valid_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_slot
    vec_operand_slot #(.W(NIB_W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s[k]),
      .d     (bus.nib_in),
      .q     (slot_q_s[k])
    );
  end

  assign bus.nib_ready = nib_ready_s;
  assign bus.op_a      = slot_q_s[IDX_A];
  assign bus.op_b      = slot_q_s[IDX_B];
  assign bus.op_c      = slot_q_s[IDX_C];
  assign bus.op_d      = slot_q_s[IDX_D];
  assign bus.ops_valid = ops_valid_r;
  assign set_cnt       = set_cnt_r;
`ifdef VEC_OPERAND_LOADER_PARITY_EN
  assign par_err       = par_err_r;
`else
  // Parity flag is constant zero without the feature; keep it out of the lint unused list.
  logic unused_par_s;
  assign unused_par_s = par_err_r;
`endif

endmodule

// File: tb/tb_vec_operand_loader.sv
// tb_vec_operand_loader: directed scenarios plus randomized traffic, checked against a
// set-level reference model (list of nibbles collected so far, held flag, accepted count).
module tb_vec_operand_loader;

  localparam int NIB_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] set_cnt;
`ifdef VEC_OPERAND_LOADER_PARITY_EN
  logic             par_err;
`endif

  vec_operand_loader_if #(.NIB_W(NIB_W)) bus ();

  vec_operand_loader #(.NIB_W(NIB_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus.slave),
    .set_cnt (set_cnt)
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [3:0] m_ops [4];
  logic [3:0] m_q [$];
  bit         m_held;
  int         m_sets;
  bit         m_perr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ops[i] = 4'h0;
    m_q.delete();
    m_held = 1'b0;
    m_sets = 0;
    m_perr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.ops_valid), 32'(m_held));
    check_eq({tag, "_cnt"},   32'(set_cnt), 32'(m_sets % 256));
    check_eq({tag, "_opa"},   32'(bus.op_a), 32'(m_ops[0]));
    check_eq({tag, "_opb"},   32'(bus.op_b), 32'(m_ops[1]));
    check_eq({tag, "_opc"},   32'(bus.op_c), 32'(m_ops[2]));
    check_eq({tag, "_opd"},   32'(bus.op_d), 32'(m_ops[3]));
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    check_eq({tag, "_perr"},  32'(par_err), 32'(m_perr));
`endif
  endtask

  // One clock: drive inputs, check ready, clock, advance model, check outputs.
  task automatic step(input string tag, input logic v, input logic [3:0] n, input logic f,
                      input logic r, input logic p_bad);
    logic bad;
    bus.nib_valid = v;
    bus.nib_in    = n;
    flush         = f;
    bus.ops_ready = r;
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    bus.nib_par   = (^n) ^ p_bad;
    bad           = p_bad;
`else
    bad           = 1'b0;
`endif
    #1;
    check_eq({tag, "_rdy"}, 32'(bus.nib_ready), 32'(!m_held && !f));
    @(posedge clk);
    if (f) begin
      m_q.delete();
      m_held = 1'b0;
      m_perr = 1'b0;
    end else if (m_held) begin
      if (r) begin
        m_held = 1'b0;
        m_sets = m_sets + 1;
      end
    end else if (v) begin
      if (bad) begin
        m_q.delete();
        m_perr = 1'b1;
      end else begin
        m_ops[m_q.size()] = n;
        m_q.push_back(n);
        if (m_q.size() == 4) begin
          m_held = 1'b1;
          m_q.delete();
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.nib_valid = 1'b0;
    bus.nib_in    = 4'h0;
    bus.ops_ready = 1'b0;
`ifdef VEC_OPERAND_LOADER_PARITY_EN
    bus.nib_par   = 1'b0;
`endif
    model_reset();
    #2;
    check_eq("rst_valid", 32'(bus.ops_valid), 32'd0);
    check_eq("rst_cnt",   32'(set_cnt), 32'd0);
    check_eq("rst_opa",   32'(bus.op_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_rdy", 32'(bus.nib_ready), 32'd1);

    // basic set 3,5,C,A
    step("s1", 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    step("s1", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step("s1", 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    check_eq("s1_notyet", 32'(bus.ops_valid), 32'd0);
    step("s1", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    check_eq("s1_valid", 32'(bus.ops_valid), 32'd1);
    check_eq("s1_opa", 32'(bus.op_a), 32'h3);
    check_eq("s1_opb", 32'(bus.op_b), 32'h5);
    check_eq("s1_opc", 32'(bus.op_c), 32'hC);
    check_eq("s1_opd", 32'(bus.op_d), 32'hA);
    check_eq("s1_rdy", 32'(bus.nib_ready), 32'd0);
    check_eq("s1_cnt", 32'(set_cnt), 32'd0);

    // hold for 10 cycles with toggling nib_valid, then accept
    for (int i = 0; i < 10; i++) step("hold", 1'(i % 2), 4'hF, 1'b0, 1'b0, 1'b0);
    check_eq("hold_opd", 32'(bus.op_d), 32'hA);
    check_eq("hold_valid", 32'(bus.ops_valid), 32'd1);
    step("acc", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_eq("acc_valid", 32'(bus.ops_valid), 32'd0);
    check_eq("acc_cnt", 32'(set_cnt), 32'd1);
    check_eq("acc_rdy", 32'(bus.nib_ready), 32'd1);

    // flush mid-set with a simultaneous nibble
    step("fl", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step("fl", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    step("fl", 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    check_eq("fl_opa_kept", 32'(bus.op_a), 32'h1);
    check_eq("fl_opc_kept", 32'(bus.op_c), 32'hC);
    for (int i = 0; i < 4; i++) step("fl4", 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    check_eq("fl4_valid", 32'(bus.ops_valid), 32'd1);
    check_eq("fl4_ops", 32'({bus.op_a, bus.op_b, bus.op_c, bus.op_d}), 32'h4444);

    // flush and accept together while held
    step("flacc", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    check_eq("flacc_valid", 32'(bus.ops_valid), 32'd0);
    check_eq("flacc_cnt", 32'(set_cnt), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // asynchronous reset after the 3rd nibble
    step("rs", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step("rs", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    step("rs", 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    step("rs", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    bus.nib_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rs_ops", 32'({bus.op_a, bus.op_b, bus.op_c, bus.op_d}), 32'h0000);
    check_eq("rs_valid", 32'(bus.ops_valid), 32'd0);
    check_eq("rs_cnt", 32'(set_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 256 full sets: counter wraps to zero
    for (int s = 0; s < 256; s++) begin
      for (int i = 0; i < 4; i++) step("wr", 1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
      step("wr", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      if (s == 254) check_eq("wr_255", 32'(set_cnt), 32'd255);
    end
    check_eq("wr_wrap", 32'(set_cnt), 32'd0);

`ifdef VEC_OPERAND_LOADER_PARITY_EN
    // bad parity on the 2nd nibble restarts the set
    step("pe", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step("pe", 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    check_eq("pe_err", 32'(par_err), 32'd1);
    for (int i = 0; i < 3; i++) step("pe", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    check_eq("pe_novalid", 32'(bus.ops_valid), 32'd0);
    step("pe", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    check_eq("pe_valid", 32'(bus.ops_valid), 32'd1);
    check_eq("pe_ops", 32'({bus.op_a, bus.op_b, bus.op_c, bus.op_d}), 32'h5556);
    step("pe", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_eq("pe_clr", 32'(par_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_operand_loader.md
Name: vec_operand_loader

Overview:
- Upstream feeder for the 4-bit vector concatenation / register-bank combinational stage.
- Accepts a serial stream of 4-bit nibbles over a valid/ready handshake and assembles them, in order, into the four operands a, b, c, d.
- Holds the assembled set stable on parallel outputs with ops_valid until the consumer accepts it. This guarantees the downstream combinational logic sees a coherent operand set, never a mix of old and new operands.

Parameters:
- NIB_W, 4, width of each nibble and operand.
- CNT_W, 8, width of the completed-set counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- nib_in  input  NIB_W  serial operand nibble.
- nib_valid  input  1  nib_in is valid this cycle.
- nib_ready  output  1  loader can accept a nibble this cycle.
- flush  input  1  synchronous abort: discard partial or held set.
- op_a  output  NIB_W  assembled operand a (first nibble).
- op_b  output  NIB_W  assembled operand b (second nibble).
- op_c  output  NIB_W  assembled operand c (third nibble).
- op_d  output  NIB_W  assembled operand d (fourth nibble).
- ops_valid  output  1  op_a..op_d form a complete, stable set.
- ops_ready  input  1  consumer accepts the held set.
- set_cnt  output  CNT_W  number of sets accepted by the consumer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - op_a..op_d = 0; ops_valid = 0; set_cnt = 0.
  - State = COLLECT; index = 0; nib_ready = 1 once rst_n deasserts.
- States: COLLECT (index 0..3), HOLD.
- nib_ready = 1 iff state == COLLECT and flush == 0. It is registered-state based, with no combinational path from nib_valid.
- COLLECT transfer occurs when nib_valid && nib_ready:
  - index 0 writes op_a, index 1 writes op_b, index 2 writes op_c, index 3 writes op_d.
  - index increments by 1 per transfer.
  - The transfer at index 3 moves to HOLD and sets ops_valid = 1 on the next edge.
  - Latency: ops_valid rises the cycle after the 4th transfer. Minimum 4 cycles per set.
- No transfer (nib_valid low) leaves all state unchanged; there is no timeout.
- While in COLLECT, ops_valid = 0. Partially written operands are visible but not valid; the consumer must ignore them.
- HOLD:
  - op_a..op_d are frozen and ops_valid = 1; nib_ready = 0.
  - ops_ready high: next edge clears ops_valid, returns to COLLECT index 0, and increments set_cnt.
  - No bypass: the first nibble of the next set is accepted no earlier than the cycle after acceptance.
- set_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- flush high (any state):
  - Next edge: COLLECT index 0, ops_valid = 0; op_a..op_d are retained (not cleared); set_cnt is unchanged.
  - Flush wins over a simultaneous nib_valid (nibble dropped, since nib_ready = 0) and over a simultaneous ops_ready (set_cnt not incremented).
- rst_n asserted mid-set or mid-HOLD: immediate return to reset values, with no completion of the pending set.
- ops_valid, once high, never drops without ops_ready, flush, or reset.

Optional Feature:
- Macro: VEC_OPERAND_LOADER_PARITY_EN.
- Defined:
  - Adds input nib_par (1 bit, even parity of nib_in) and output par_err (1 bit, sticky).
  - On a transfer with a parity mismatch, par_err is set and the set being assembled is discarded at the point of failure: the loader returns to COLLECT index 0 and HOLD is not entered.
  - par_err clears only on reset or flush.
- Undefined: no nib_par/par_err ports and no checking; behaviour as above.

Decomposition:
- Shared package vec_pkg:
  - NIB_W default constant.
  - State enum {COLLECT, HOLD}.
  - Operand index constants IDX_A=0, IDX_B=1, IDX_C=2, IDX_D=3.
- One natural sub-module, vec_operand_slot: a NIB_W-wide register with a load enable and asynchronous active-low reset, instantiated four times.
- Index decode, FSM and counter stay in the top level.

Test Plan:
- Nibbles 0x3, 0x5, 0xC, 0xA, each with nib_valid, ops_ready = 0 -> ops_valid rises the cycle after the 4th transfer; op_a=3, op_b=5, op_c=C, op_d=A; nib_ready = 0 while held; set_cnt = 0.
- Same set held 10 cycles while nib_valid toggles with 0xF -> operands unchanged; ops_ready pulse -> ops_valid = 0 next cycle, set_cnt = 1, nib_ready = 1.
- Two nibbles (0x1, 0x2) then flush together with nib_valid (0x7) -> index back to 0, 0x7 not captured; the next four nibbles 0x4, 0x4, 0x4, 0x4 produce op_a..op_d = 4.
- HOLD with flush and ops_ready in the same cycle -> ops_valid = 0, set_cnt unchanged.
- 256 complete sets with CNT_W = 8 -> set_cnt wraps to 0.
- rst_n pulled low after the 3rd nibble -> all outputs 0 immediately. With VEC_OPERAND_LOADER_PARITY_EN, a bad parity on the 2nd nibble -> par_err = 1, no ops_valid, loader restarts at index 0.
